// File: rtl/gray2binary_sync.sv
// Synchronizes a Gray-coded pointer from another clock domain and decodes it to binary,
// reporting each change with an update strobe and step size. G2B_STEP_CHECK_EN adds multi-bit-change detection and an error counter.
module gray2binary_sync #(
    parameter int GRAY_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [GRAY_WIDTH-1:0] i_gray,
    input  logic                  i_err_clr,
    output logic [GRAY_WIDTH-1:0] o_binary,
    output logic                  o_update,
    output logic [GRAY_WIDTH-1:0] o_step,
    output logic                  o_step_err,
    output logic [7:0]            o_err_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    logic [GRAY_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [GRAY_WIDTH-1:0] w_sync_gray;
    logic [GRAY_WIDTH-1:0] w_decode;
    logic                  w_change;
    logic [GRAY_WIDTH-1:0] r_binary;
    logic                  r_update;
    logic [GRAY_WIDTH-1:0] r_step;
    state_t                r_state;
    state_t                w_state_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_gray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_gray = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        w_decode = '0;
        for (int i = 0; i < GRAY_WIDTH; i++) begin
            w_decode[i] = ^(w_sync_gray >> i);
        end
    end

    assign w_change = (w_decode != r_binary);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_binary <= '0;
            r_update <= 1'b0;
            r_step   <= '0;
        end else if (w_change) begin
            r_binary <= w_decode;
            r_update <= 1'b1;
            r_step   <= w_decode - r_binary;
        end else begin
            r_update <= 1'b0;
            r_step   <= '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The first update after reset may be an arbitrary jump; only later ones are checked.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_change) w_state_next = ST_ARMED;
            ST_ARMED: w_state_next = ST_ARMED;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign o_binary = r_binary;
    assign o_update = r_update;
    assign o_step   = r_step;

`ifdef G2B_STEP_CHECK_EN
    logic [GRAY_WIDTH-1:0] r_prev_gray;
    logic [GRAY_WIDTH-1:0] w_diff;
    logic                  w_multi_bit;
    logic                  r_step_err;
    logic [7:0]            r_err_cnt;

    // x & (x-1) is nonzero exactly when x has more than one bit set.
    assign w_diff      = w_sync_gray ^ r_prev_gray;
    assign w_multi_bit = |(w_diff & (w_diff - 1'b1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_gray <= '0;
            r_step_err  <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_prev_gray <= w_sync_gray;
            r_step_err  <= (r_state == ST_ARMED) && w_change && w_multi_bit;
            if (i_err_clr) begin
                r_err_cnt <= {7'd0, r_step_err};
            end else if (r_step_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_step_err = r_step_err;
    assign o_err_cnt  = r_err_cnt;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign o_step_err       = 1'b0;
    assign o_err_cnt        = 8'd0;
`endif

endmodule

// File: doc/gray2binary_sync.md
# gray2binary_sync

Receive-side companion to the binary-to-Gray encoder. It samples a Gray-coded value, typically a FIFO read or write pointer launched from another clock domain, through a synchronizer chain in the local clock domain. It decodes that value to binary through a registered stage and reports each change with a one-cycle update strobe and the binary step size. Async-FIFO status logic uses it to obtain the far-side pointer in binary, and it can optionally flag illegal multi-bit Gray transitions.

## Interface
- GRAY_WIDTH, 4, width of the Gray input and of the binary output (≥2)
- SYNC_STAGES, 2, number of synchronizer flops ahead of the decoder (≥2)
- i_clk  input  1  local clock; all logic on its rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_gray  input  GRAY_WIDTH  Gray-coded value from the source domain; only one bit may change per source update
- i_err_clr  input  1  synchronous clear of the error counter
- o_binary  output  GRAY_WIDTH  registered binary decode of the synchronized Gray value
- o_update  output  1  one-cycle pulse when o_binary takes a new value
- o_step  output  GRAY_WIDTH  (new − old) mod 2^GRAY_WIDTH, valid while o_update=1, else 0
- o_step_err  output  1  one-cycle pulse: synchronized Gray changed in more than one bit (see Configuration)
- o_err_cnt  output  8  saturating count of o_step_err pulses

## Operation
- **Synchronizer:** SYNC_STAGES flops, all reset to 0. The last stage is `sync_gray`. A `prev_gray` register holds the previous `sync_gray`.
- **Decode (combinational on sync_gray):**
  - b[W−1] = g[W−1]
  - b[i] = b[i+1] ^ g[i] for i = W−2 down to 0
- **Update stage:** when the decode differs from o_binary:
  - o_binary ← decode
  - o_update ← 1
  - o_step ← decode − o_binary, truncated to GRAY_WIDTH
  - Otherwise o_update=0, o_step=0, and o_binary holds.
- **Arm state, two states:**
  - IDLE (after reset) moves to ARMED on the first cycle in which o_update fires.
  - ARMED is left only by reset.
  - The first update after reset may be a large jump from 0. It is reported normally, but no step check applies to it.
- **Step check:** applies in ARMED only, when enabled.
  - popcount(sync_gray ^ prev_gray) > 1 → o_step_err pulse in the same cycle as the corresponding o_update.
  - o_binary still follows the decoded value; the block never corrects the value.
- **Error counter:**
  - Increments on o_step_err and saturates at 255.
  - i_err_clr alone sets it to 0.
  - If i_err_clr and o_step_err occur in the same cycle, the counter becomes 1.
- **Wrap-around:** decode 0 after 2^W−1 gives o_step=1, which is a legal single-bit Gray change.

## Timing
- i_gray change to o_binary/o_update: SYNC_STAGES+1 i_clk cycles.
- o_step and o_step_err are aligned with o_update.
- o_err_cnt reflects a pulse one cycle after o_step_err.
- **Reset values:**
  - o_binary=0, o_update=0, o_step=0, o_step_err=0, o_err_cnt=0
  - synchronizer=0, prev_gray=0, state=IDLE
- **Reset mid-operation:**
  - All state clears immediately and asynchronously; outputs go to the reset values without waiting for a clock.
  - After release, the chain refills. A nonzero i_gray produces one update at SYNC_STAGES+1 cycles, which returns the block to ARMED with no error.
- **Back-to-back changes:** the source may change every i_clk cycle. Each distinct synchronized value produces its own o_update; there is no coalescing beyond what the synchronizer introduces.

## Configuration
- Macro: G2B_STEP_CHECK_EN.
- **Defined:**
  - prev_gray, the popcount compare, o_step_err and o_err_cnt are implemented as described above.
- **Undefined:**
  - That logic is not built.
  - o_step_err and o_err_cnt are tied to 0, and i_err_clr is ignored.
  - o_binary, o_update, o_step and the arm state behave identically to the defined case.

## Test plan
All scenarios use GRAY_WIDTH=4 and SYNC_STAGES=2.
- **Reset:** assert i_rst with i_gray=4'b1111 → all outputs 0 immediately. Release → exactly 3 cycles later o_binary=4'd10, o_update=1, o_step=4'd10, o_step_err=0.
- **Sequential count:** drive i_gray=0111, 0101, 0100 on consecutive cycles from o_binary=4 → o_binary 5, 6, 7 on consecutive cycles, each with o_update=1, o_step=1, o_step_err=0.
- **Wrap:** step from Gray 1000 (15) to 0000 → o_binary=0, o_step=1, no error.
- **Illegal jump (macro on):** in ARMED with o_binary=0, drive Gray 0011 (2) → o_binary=2, o_step=2, o_step_err=1. o_err_cnt=1 one cycle later. Assert i_err_clr together with a second illegal jump → o_err_cnt=1.
- **Saturation:** 300 illegal jumps → o_err_cnt holds at 255. With the macro off, the same stimulus → o_step_err and o_err_cnt stay 0, while o_binary is identical to the macro-on run.
- **Mid-run reset:** assert i_rst while o_binary=9 → outputs 0 within the same cycle, state returns to IDLE, and the first post-release update raises no error.
